// File: rtl/fp_pkg.sv
// Shared constants and helpers for the RISC5 floating-point unit.
// Used by both the shift-add multiplier and the restoring divider.
package fp_pkg;

    localparam int          EXP_BIAS   = 127;
    localparam int          DIV_ITER   = 26;
    localparam logic [4:0]  DIV_DONE   = 5'(DIV_ITER + 1);
    localparam logic [31:0] FLUSH_ZERO = 32'h0000_0000;
    localparam logic [7:0]  SAT_EXP    = 8'hFF;

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_ITER,
        PH_HOLD
    } div_phase_t;

    // Step 0 loads the operands, steps 1..26 iterate, and DONE holds the result.
    function automatic div_phase_t div_phase(input logic [4:0] s);
        if (s == 5'd0)
            return PH_LOAD;
        else if (s == DIV_DONE)
            return PH_HOLD;
        else
            return PH_ITER;
    endfunction

endpackage

// File: rtl/fp_pack.sv
// Packs a sign, an unbounded exponent and a rounded fraction into a single-precision word.
// Forced-zero has priority over saturation; out-of-range exponents saturate or flush to zero.
module fp_pack
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [9:0]  expo,
    input  logic [22:0] frac,
    input  logic        zero,
    input  logic        sat,
    output logic [31:0] z
);

    always_comb begin
        if (zero)
            z = FLUSH_ZERO;
        else if (sat || ($signed(expo) >= 10'sd255))
            z = {sign, SAT_EXP, 23'h0};
        else if ($signed(expo) <= 10'sd0)
            z = FLUSH_ZERO;
        else
            z = {sign, expo[7:0], frac};
    end

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle single-precision divider z = x / y using restoring division, one quotient bit per enabled clock.
// It shares the run/stall handshake with the multiplier, so x and y are held stable while stall is high.
module fp_divider
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);

    logic [4:0]  s, s_next;
    logic [24:0] r, r_next;
    logic [25:0] q, q_next;
    logic [25:0] d;
    logic [23:0] xm, ym;
    logic [7:0]  xe, ye;
    logic        sign;
    logic [9:0]  e1;
    logic [22:0] mant_src;
    logic        rnd_bit;
    logic [22:0] frac;

    assign xm   = {1'b1, x[22:0]};
    assign ym   = {1'b1, y[22:0]};
    assign xe   = x[30:23];
    assign ye   = y[30:23];
    assign sign = x[31] ^ y[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= 5'd0;
            r <= 25'd0;
            q <= 26'd0;
        end else if (ce) begin
            s <= s_next;
            r <= r_next;
            q <= q_next;
        end
    end

    // The remainder stays below 2*ym, so a non-negative difference always fits after the shift.
    always_comb begin
        d      = {1'b0, r} - {2'b00, ym};
        s_next = 5'd0;
        r_next = r;
        q_next = q;
        if (run)
            s_next = (s == DIV_DONE) ? DIV_DONE : s + 5'd1;
        case (div_phase(s))
            PH_LOAD: begin
                r_next = {1'b0, xm};
                q_next = 26'd0;
            end
            PH_ITER: begin
                r_next = d[25] ? (r << 1) : (d[24:0] << 1);
                q_next = {q[24:0], ~d[25]};
            end
            default: begin
                r_next = r;
                q_next = q;
            end
        endcase
    end

    always_comb begin
        stall = run & (s != DIV_DONE);
    end

    // Round half up by adding the bit just below the kept fraction; the quotient range prevents a carry-out.
    assign mant_src = q[25] ? q[24:2] : q[23:1];
    assign rnd_bit  = q[25] ? q[1] : q[0];
    assign frac     = mant_src + {22'd0, rnd_bit};
    assign e1       = {2'b00, xe} - {2'b00, ye} + 10'(EXP_BIAS - 1) + {9'd0, q[25]};

    fp_pack u_pack (
        .sign (sign),
        .expo (e1),
        .frac (frac),
        .zero (xe == 8'd0),
        .sat  (ye == 8'd0),
        .z    (z)
    );

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: a table of operand/result vectors plus hand-written control sequences.
// Expected quotients are queued when a divide starts and compared once stall drops.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        run;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] z;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    fp_divider dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .run   (run),
        .x     (x),
        .y     (y),
        .stall (stall),
        .z     (z)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act == req)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic apply_stimulus(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zexp);
        x   = xi;
        y   = yi;
        run = 1'b1;
        exp_q.push_back(zexp);
    endtask

    // Counts cycles with stall high, sampled 1 time unit after each falling edge.
    task automatic wait_done(output int cycles);
        cycles = 0;
        forever begin
            #1;
            if (stall !== 1'b1 || cycles >= 200)
                break;
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 200) begin
            n_checks++;
            $display("[TB] FAIL stall_timeout: got stall still high after %0d cycles, required low", cycles);
        end
    endtask

    task automatic check_output(input string name);
        logic [31:0] req;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL %s: got empty scoreboard, required a queued result", name);
        end else begin
            req = exp_q.pop_front();
            check32(name, z, req);
        end
    endtask

    task automatic finish_op();
        run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;

        vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000};
        vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB};
        vecs[2]  = '{32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000};
        vecs[3]  = '{32'h0000_0000, 32'h4040_0000, 32'h0000_0000};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000};
        vecs[6]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000};
        vecs[7]  = '{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000};
        vecs[8]  = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000};
        vecs[9]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        vecs[10] = '{32'h4120_0000, 32'hC080_0000, 32'hC020_0000};

        rst = 1'b1;
        ce  = 1'b1;
        run = 1'b0;
        x   = 32'h0;
        y   = 32'h4040_0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check32("reset_stall_idle", {31'd0, stall}, 32'd0);
        check32("reset_z_xzero", z, 32'h0);
        run = 1'b1;
        #1;
        check32("reset_stall_run", {31'd0, stall}, 32'd1);
        finish_op();

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].x, vecs[i].y, vecs[i].z);
            wait_done(c);
            check_int($sformatf("latency_vec%0d", i), c, 27);
            check_output($sformatf("z_vec%0d", i));
            if (i == 0) begin
                @(negedge clk);
                #1;
                check32("hold_z", z, vecs[0].z);
                check32("hold_stall", {31'd0, stall}, 32'd0);
            end
            finish_op();
        end

        // ce low for 5 cycles stretches the stall to 32 cycles
        apply_stimulus(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        repeat (10) @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        wait_done(c);
        check_int("ce_low_latency", c + 15, 32);
        check_output("ce_low_z");
        finish_op();

        apply_stimulus(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        repeat (10) @(negedge clk);
        #1;
        check32("rst_mid_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_done(c);
        check_int("rst_mid_latency", c, 27);
        check_output("rst_mid_z");
        finish_op();

        // reset must win over a low clock enable
        apply_stimulus(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
        repeat (10) @(negedge clk);
        ce  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        wait_done(c);
        check_int("rst_over_ce_latency", c, 27);
        check_output("rst_over_ce_z");
        finish_op();

        x   = 32'h40C0_0000;
        y   = 32'h4000_0000;
        run = 1'b1;
        repeat (10) @(negedge clk);
        run = 1'b0;
        #1;
        check32("run_drop_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        apply_stimulus(32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000);
        wait_done(c);
        check_int("after_abort_latency", c, 27);
        check_output("after_abort_z");
        finish_op();

        check_int("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
# fp_divider

Multi-cycle IEEE-754 single-precision divider (z = x / y) for the RISC5 floating-point unit, and the inverse operation of the shift-add FP multiplier. It uses restoring long division, one quotient bit per enabled clock. It sits beside the multiplier on the CPU execute path and shares its `run`/`stall` handshake, so the CPU holds `x`/`y` and waits while `stall` is high. Denormals are flushed to zero, and NaN/Inf are not interpreted, matching the rest of the FPU.

## Interface
- Parameters: none. The iteration count and bias are fixed package constants.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable. When low, every register holds.
- `run`  in  1  high for the whole duration of a divide request.
- `x`  in  32  dividend (sign, 8-bit exponent, 23-bit fraction). Stable while `run` is high.
- `y`  in  32  divisor, same format. Stable while `run` is high.
- `stall`  out  1  busy. Equals `run & (S != DONE)`.
- `z`  out  32  quotient. Combinational from registered state and `x`/`y`; valid when `run & ~stall`.

## Operation
- **State:** 5-bit counter `S`, 25-bit remainder `R`, 26-bit quotient shift register `Q`.
- **Mantissas:** `xm = {1, x[22:0]}` and `ym = {1, y[22:0]}`, each 24 bits.
- **S == 0** (first cycle with `run`): `R <= {0, xm}`, `Q <= 0`.
- **S = 1..26 (iterate):**
  - `d = R - {0, ym}`, computed 26 bits wide.
  - If `d` is non-negative: `R <= d << 1` and shift 1 into `Q[0]`.
  - Otherwise: `R <= R << 1` and shift 0 into `Q[0]`.
- **Quotient:** after 26 iterations, `Q = floor(xm * 2^25 / ym)`, which lies in [2^24, 2^26).
- **Counter:** `S <= run ? (S == DONE ? DONE : S + 1) : 0`. `S` saturates at `DONE = 27` while `run` stays high.
- **Sign:** `x[31] ^ y[31]`.
- **Normalize and round** (round-half-up, no sticky bit, same as the multiplier):
  - If `Q[25]`: `m = Q[25:1] + 1`, fraction = `m[23:1]`.
  - Else: `m = Q[24:0] + 1`, fraction = `m[23:1]`.
  - Rounding cannot carry out: `Q[24:0] <= 2^25 - 3` whenever `Q[25] = 0`.
- **Exponent:** `e1 = xe - ye + 126 + Q[25]`, evaluated as a 10-bit signed value.
- **Result select** (checked in this order):
  1. `xe == 0` gives `z = 0`. This includes 0/0.
  2. `ye == 0` (divide by zero) gives `z = {sign, 8'hFF, 23'h0}`.
  3. `e1 >= 255` (overflow) gives `{sign, 8'hFF, 23'h0}`.
  4. `e1 <= 0` (underflow) gives `z = 0`.
  5. Otherwise `z = {sign, e1[7:0], fraction}`.

## Timing
- **Reset:** `S`, `R` and `Q` are cleared to 0.
  - `stall` equals `run`, because `S = 0`.
  - `z` is 0 whenever `xe == 0`; otherwise it is a don't-care until `DONE`.
- **Latency:** with `ce` held high, `stall` is high for exactly 27 cycles after `run` rises. `z` is valid in cycle 28, the first cycle with `stall` low.
- **`ce` low:** freezes `S`, `R` and `Q`. Stall cycles extend by the number of `ce`-low cycles.
- **`run` drop:** `run` falling at any `S` aborts. `S` returns to 0 on the next enabled edge, and `stall` drops immediately because it is combinational.
- **Back-to-back:** `run` low for one enabled cycle is sufficient before the next operation.
- **`rst` mid-operation:** the operation restarts from `S = 0` if `run` is still high. It costs a full 27 more stall cycles.
- **`rst` priority:** `rst` has priority over `ce`.
- **Result hold:** `z` stays stable while `S == DONE` and `run` is high.

## Structure
- **Package `fp_pkg`:** `EXP_BIAS = 127`, `DIV_ITER = 26`, `DIV_DONE = 27`, the flush-zero constant, and the saturation exponent `8'hFF`. These are shared with the multiplier.
- **Optional combinational sub-module `fp_pack`:** sign, exponent and rounded mantissa in, 32-bit result out. It handles the zero and saturation select and is reusable by the multiplier. Iteration logic stays inline.

## Test plan
- 6.0 / 2.0 (`x = 0x40C00000`, `y = 0x40000000`) → `z = 0x40400000`. Bench checks `stall` high for exactly 27 cycles, then low.
- 1.0 / 3.0 (`0x3F800000` / `0x40400000`) → `0x3EAAAAAB`, exercising the round-up path.
- -1.5 / 0.5 (`0xBFC00000` / `0x3F000000`) → `0xC0400000`.
- Zero and divide-by-zero:
  - `x = 0`, any `y` → `0x00000000`.
  - `x = 0x3F800000`, `y = 0` → `0x7F800000`.
  - `x = 0xBF800000`, `y = 0` → `0xFF800000`.
- Range limits:
  - Overflow: `0x7F000000` / `0x00800000` → `0x7F800000`.
  - Underflow: `0x00800000` / `0x7F000000` → `0`.
- Control sequencing on 6.0 / 2.0:
  - `ce` low for 5 cycles mid-operation → `stall` lasts 32 cycles, same result.
  - `rst` pulsed at `S = 10` with `run` held → 27 further stall cycles, then the correct result.
  - `run` dropped at `S = 10` → `stall` falls immediately.
